// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// Pipeline side is the master; the unit is the slave.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, cancel,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, cancel,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO plus MTHI/MTLO; result WIDTH+1 edges after start.
// busy stalls HI/LO consumers; start while busy is dropped; cancel aborts without writing HI/LO.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  mul_div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] a_raw;

  always_comb begin
    // Signed ops are 000 and 010; both have op[0]=0.
    a_neg     = ~bus.op[0] & bus.a[WIDTH-1];
    b_neg     = ~bus.op[0] & bus.b[WIDTH-1];
    abs_a     = a_neg ? -bus.a : bus.a;
    abs_b     = b_neg ? -bus.b : bus.b;
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opa} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb};
    prod      = {acc_hi, acc_lo};
    prod_fix  = (sa ^ sb) ? -prod : prod;
    quo_fix   = (sa ^ sb) ? -acc_lo : acc_lo;
    rem_fix   = sa ? -acc_hi : acc_hi;
    a_raw     = sa ? -opa : opa;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.cancel) begin
            case (bus.op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                opa    <= abs_a;
                opb    <= abs_b;
                sa     <= a_neg;
                sb     <= b_neg;
                is_div <= bus.op[1];
                acc_hi <= '0;
                // Divide shifts the dividend out of acc_lo; multiply shifts the multiplier.
                acc_lo <= bus.op[1] ? abs_a : abs_b;
                cnt    <= '0;
                state  <= CALC;
              end
              3'b100:  hi_q <= bus.a;
              3'b101:  lo_q <= bus.a;
              default: ;
            endcase
          end
        end
        CALC: begin
          if (bus.cancel) begin
            state <= IDLE;
          end else begin
            if (is_div) begin
              // div_trial[WIDTH] set means the trial subtraction went negative: restore.
              if (div_trial[WIDTH]) begin
                acc_hi <= div_shift[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
              end else begin
                acc_hi <= div_trial[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
              end
            end else begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state <= FINISH;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          if (!bus.cancel) begin
            done_q <= 1'b1;
            if (is_div) begin
              if (opb == '0) begin
                lo_q <= '1;
                hi_q <= a_raw;
              end else begin
                lo_q <= quo_fix;
                hi_q <= rem_fix;
              end
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32: arithmetic results, latency, MTHI/MTLO, cancel and reset.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Drives one request, then scrambles a/b so late operand changes would show.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit busy_ok, output logic busy_at_done,
                       output logic done_after);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 32'hDEADBEEF; bus.b = 32'h00000001;
    lat = -1; busy_ok = 1'b1; busy_at_done = 1'bx; done_after = 1'bx;
    for (int k = 0; k < 40; k++) begin
      if (bus.done === 1'b1) begin
        lat = k;
        busy_at_done = bus.busy;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    done_after = bus.done;
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.cancel = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    rst = 1'b0;
  endtask

  // Runs a table of mult/div vectors, each checked for result, latency and handshake shape.
  task automatic run_table(input string tag, input logic [2:0] ops[3], input logic [31:0] va[3],
                           input logic [31:0] vb[3], input logic [31:0] ehi[3], input logic [31:0] elo[3]);
    int   lat;
    bit   bok;
    logic bd;
    logic da;
    for (int i = 0; i < 3; i++) begin
      do_op(ops[i], va[i], vb[i], lat, bok, bd, da);
      total++; if (lat !== 33) begin bad++; $display("FAIL %s%0d_latency: got %0d want 33", tag, i, lat); end
      total++; if (bok !== 1'b1) begin bad++; $display("FAIL %s%0d_busy_hold: busy dropped early", tag, i); end
      total++; if (bd !== 1'b0) begin bad++; $display("FAIL %s%0d_busy_at_done: got %b want 0", tag, i, bd); end
      total++; if (da !== 1'b0) begin bad++; $display("FAIL %s%0d_done_pulse: got %b want 0", tag, i, da); end
      total++; if (bus.hi !== ehi[i]) begin bad++; $display("FAIL %s%0d_hi: got %h want %h", tag, i, bus.hi, ehi[i]); end
      total++; if (bus.lo !== elo[i]) begin bad++; $display("FAIL %s%0d_lo: got %h want %h", tag, i, bus.lo, elo[i]); end
    end
  endtask

  task automatic test_mult;
    logic [2:0]  ops[3];
    logic [31:0] va[3], vb[3], ehi[3], elo[3];
    ops = '{3'b000, 3'b001, 3'b000};
    va  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h00000007};
    vb  = '{32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFA};
    ehi = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF};
    elo = '{32'hFFFFFFF1, 32'h00000001, 32'hFFFFFFD6};
    run_table("mult", ops, va, vb, ehi, elo);
  endtask

  task automatic test_div;
    logic [2:0]  ops[3];
    logic [31:0] va[3], vb[3], ehi[3], elo[3];
    ops = '{3'b011, 3'b010, 3'b010};
    va  = '{32'd100, 32'hFFFFFFF9, 32'h80000000};
    vb  = '{32'd7, 32'd2, 32'hFFFFFFFF};
    ehi = '{32'h00000002, 32'hFFFFFFFF, 32'h00000000};
    elo = '{32'h0000000E, 32'hFFFFFFFD, 32'h80000000};
    run_table("div", ops, va, vb, ehi, elo);
  endtask

  task automatic test_div_zero;
    logic [2:0]  ops[3];
    logic [31:0] va[3], vb[3], ehi[3], elo[3];
    ops = '{3'b010, 3'b011, 3'b010};
    va  = '{32'h12345678, 32'd5, 32'hFFFFFFFB};
    vb  = '{32'd0, 32'd0, 32'd0};
    ehi = '{32'h12345678, 32'h00000005, 32'hFFFFFFFB};
    elo = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    run_table("divz", ops, va, vb, ehi, elo);
  endtask

  task automatic test_mthi_mtlo;
    @(negedge clk); bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'hAAAA0000;
    @(negedge clk); bus.start = 1'b0;
    total++; if (bus.hi !== 32'hAAAA0000) begin bad++; $display("FAIL mthi_hi: got %h want aaaa0000", bus.hi); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mthi_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL mthi_done: got %b want 0", bus.done); end
    bus.start = 1'b1; bus.op = 3'b101; bus.a = 32'h00005555;
    @(negedge clk); bus.start = 1'b0;
    total++; if (bus.lo !== 32'h00005555) begin bad++; $display("FAIL mtlo_lo: got %h want 00005555", bus.lo); end
    total++; if (bus.hi !== 32'hAAAA0000) begin bad++; $display("FAIL mtlo_hi_kept: got %h want aaaa0000", bus.hi); end
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL mtlo_flags: got busy=%b done=%b want 0/0", bus.busy, bus.done);
    end
    bus.start = 1'b1; bus.op = 3'b110; bus.a = 32'h01234567;
    @(negedge clk); bus.start = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.hi !== 32'hAAAA0000 || bus.lo !== 32'h00005555) begin
      bad++; $display("FAIL noop: got busy=%b hi=%h lo=%h want 0/aaaa0000/00005555", bus.busy, bus.hi, bus.lo);
    end
  endtask

  task automatic test_busy_ignore;
    int seen = -1;
    @(negedge clk); bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd2; bus.b = 32'd3;
    @(negedge clk); bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'h0000DEAD;
    @(negedge clk); bus.start = 1'b0;
    for (int k = 6; k < 45; k++) begin
      if (bus.done === 1'b1) begin seen = k; break; end
      @(negedge clk);
    end
    total++; if (seen !== 33) begin bad++; $display("FAIL busy_ignore_latency: got %0d want 33", seen); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL busy_ignore_hi: got %h want 0", bus.hi); end
    total++; if (bus.lo !== 32'h6) begin bad++; $display("FAIL busy_ignore_lo: got %h want 6", bus.lo); end
  endtask

  task automatic test_cancel;
    bit done_seen = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'h11111111;
    @(negedge clk); bus.op = 3'b101; bus.a = 32'h22222222;
    @(negedge clk); bus.op = 3'b010; bus.a = 32'd100; bus.b = 32'd3;
    @(negedge clk); bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk); bus.cancel = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL cancel_busy: got %b want 0", bus.busy); end
    for (int k = 0; k < 40; k++) begin
      if (bus.done === 1'b1) done_seen = 1'b1;
      @(negedge clk);
    end
    total++; if (done_seen !== 1'b0) begin bad++; $display("FAIL cancel_no_done: got done pulse, want none"); end
    total++; if (bus.hi !== 32'h11111111) begin bad++; $display("FAIL cancel_hi: got %h want 11111111", bus.hi); end
    total++; if (bus.lo !== 32'h22222222) begin bad++; $display("FAIL cancel_lo: got %h want 22222222", bus.lo); end
  endtask

  task automatic test_reset_mid;
    bit done_seen = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.op = 3'b001; bus.a = 32'd3; bus.b = 32'd3;
    @(negedge clk); bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      bad++; $display("FAIL rst_mid_hilo: got hi=%h lo=%h want 0/0", bus.hi, bus.lo);
    end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    for (int k = 0; k < 40; k++) begin
      if (bus.done === 1'b1) done_seen = 1'b1;
      @(negedge clk);
    end
    total++; if (done_seen !== 1'b0) begin bad++; $display("FAIL rst_mid_no_done: got done pulse, want none"); end
  endtask

  task automatic test_start_cancel;
    @(negedge clk); bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 3'b100; bus.a = 32'h00000099;
    @(negedge clk); bus.op = 3'b000; bus.a = 32'd4; bus.b = 32'd4;
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL start_cancel_mthi: got %h want 0", bus.hi); end
    @(negedge clk); bus.start = 1'b0; bus.cancel = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL start_cancel_mult_busy: got %b want 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_mthi_mtlo();
    test_busy_ignore();
    test_cancel();
    test_reset_mid();
    test_start_cancel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for the EX stage, running beside the combinational ALU.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and writes a 2*WIDTH-bit result into architectural HI/LO registers.
- Also services MTHI/MTLO writes.
- Parametrised in datapath width; stalls the pipeline via busy and supports cancellation on exception flush.

Parameters:
WIDTH, 32, operand/HI/LO width (≥4, even)
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
start  in  1  request; sampled only when busy=0
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
a  in  WIDTH  multiplicand / dividend / MTHI-MTLO source
b  in  WIDTH  multiplier / divisor
cancel  in  1  flush: abort in-flight op
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  unit occupied; pipeline must stall HI/LO consumers
done  out  1  one-cycle pulse: HI/LO just updated by mult/div

Behaviour:
- Reset (rst=1 at edge): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset overrides start and cancel, including mid-operation.
- Registered outputs: busy and done are decoded from registered state.
- States:
  - IDLE
  - CALC
  - FINISH
- IDLE:
  - start=1 with op MULT/MULTU/DIV/DIVU and cancel=0: latch a, b, op; for signed ops latch |a|, |b| plus sign bits; clear counter; go CALC.
  - start=1 with MTHI: hi<=a. With MTLO: lo<=a. Both take one edge, stay IDLE, no busy, no done.
  - Op 11x: ignored.
- CALC:
  - Multiply: one radix-2 shift-add step per edge.
  - Divide: one restoring shift-subtract step per edge.
  - After the WIDTH-th step the counter reaches WIDTH-1 and the state goes to FINISH.
- FINISH (one edge): apply sign correction and write hi/lo; go IDLE.
  - Product: negate the 2*WIDTH result when the operand signs differ (signed ops only). hi=upper half, lo=lower half.
  - Quotient to lo, negated if the signs differ. Remainder to hi, carrying the dividend's sign.
- Timing, start accepted at edge E0:
  - busy=1 from after E0 until after E_{WIDTH+1}.
  - hi/lo update at E_{WIDTH+1}.
  - done=1 for exactly the cycle after E_{WIDTH+1}; busy=0 in that same cycle.
  - For WIDTH=32, the result is visible 33 cycles after the start edge.
- start while busy=1: ignored, not queued. The unit never accepts a new op in the same edge that leaves FINISH.
- cancel=1 in CALC or FINISH: go IDLE at that edge; hi/lo keep their pre-op values; no done pulse. busy=0 next cycle.
- cancel=1 in IDLE with start=1: cancel wins; start is dropped, including MTHI/MTLO.
- Divide by zero (DIV or DIVU, b=0): full latency still applies. Result lo={WIDTH{1}}, hi=a as latched (raw, no sign fix).
- Signed overflow DIV of -2^(WIDTH-1) by -1: lo=-2^(WIDTH-1), hi=0. No trap; natural two's-complement wrap.
- Operands latched at start; changes to a/b during CALC have no effect.

Test Plan:
1. Reset, then MULT a=0xFFFFFFFD (-3), b=5 -> busy 32'd33 cycles... 33 cycles after the start edge: hi=0xFFFFFFFF, lo=0xFFFFFFF1, done one-cycle pulse with busy=0.
2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002.
3. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIV a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678 after full latency. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5.
5. MTHI a=0xAAAA0000, then MTLO a=0x5555 -> hi/lo update one edge each, busy and done stay 0. Start MULT, then pulse MTHI while busy -> MTHI ignored and the MULT result is written.
6. Start DIV, assert cancel at cycle 10 -> busy=0 next cycle, no done, hi/lo unchanged. Assert rst mid-CALC -> hi=lo=0, busy=0. start+cancel together in IDLE -> nothing happens.
